// File: rtl/wes207_spi_pkg.sv
// Shared SPI frame constants, state encoding and packing helper for the WES207 SPI block set.
// Used by the master, the slave and the register wrapper.
package wes207_spi_pkg;

  localparam int unsigned PKTSZ   = 16;
  localparam int unsigned HEADER  = 8;
  localparam int unsigned PAYLOAD = 8;
  localparam int unsigned ADDRSZ  = HEADER - 1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_m_state_t;

  // Frame layout on the wire: header {rw, addr} followed by payload, MSB first.
  function automatic logic [PKTSZ-1:0] spi_pack(input logic               rw,
                                                input logic [ADDRSZ-1:0]  addr,
                                                input logic [PAYLOAD-1:0] data);
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period divider: one tick every ClkDiv cycles while enabled, plus rise/fall
// strobes that alternate on ticks while the shift phase is enabled.
module spi_clk_gen #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic phase_en_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            tick;

  assign tick = en_i && (cnt_q == CntW'(ClkDiv - 1));

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Phase 0 means the next shift tick is a rising edge.
    if (!phase_en_i) begin
      phase_d = 1'b0;
    end else if (tick) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign tick_o = tick;
  assign rise_o = tick && phase_en_i && !phase_q;
  assign fall_o = tick && phase_en_i && phase_q;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one 16-bit {rw, addr, data} frame per accepted start, MSB first,
// read payload returned on rd_data.
module spi_master
  import wes207_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               rw,
  input  logic [ADDRSZ-1:0]  addr,
  input  logic [PAYLOAD-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic [PAYLOAD-1:0] rd_data,
  output logic               SCLK,
  output logic               SSB,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int unsigned BitW = $clog2(PKTSZ + 1);
  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;

  spi_m_state_t       state_q, state_d;
  logic [PKTSZ-1:0]   shift_tx_q, shift_tx_d;
  logic [PAYLOAD-1:0] shift_rx_q, shift_rx_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic               rw_q, rw_d;
  logic               sclk_q, sclk_d;
  logic               ssb_q, ssb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PAYLOAD-1:0] rd_data_q, rd_data_d;

  logic div_en, phase_en, tick, sclk_rise, sclk_fall;

  assign div_en   = (state_q != IDLE);
  assign phase_en = (state_q == SHIFT);

  spi_clk_gen #(
    .ClkDiv(CLK_DIV)
  ) u_clk_gen (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .en_i       (div_en),
    .phase_en_i (phase_en),
    .tick_o     (tick),
    .rise_o     (sclk_rise),
    .fall_o     (sclk_fall)
  );

  always_comb begin
    state_d    = state_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rw_d       = rw_q;
    sclk_d     = sclk_q;
    ssb_d      = ssb_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_data_d  = rd_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_tx_d = spi_pack(rw, addr, wr_data);
          shift_rx_d = '0;
          bit_cnt_d  = '0;
          rw_d       = rw;
          ssb_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          sclk_d     = 1'b1;
          // Only the last PAYLOAD samples survive, so header-phase MISO drops out naturally.
          shift_rx_d = {shift_rx_q[PAYLOAD-2:0], MISO};
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end else if (sclk_fall) begin
          sclk_d     = 1'b0;
          shift_tx_d = {shift_tx_q[PKTSZ-2:0], 1'b0};
          if (bit_cnt_q == BitW'(PKTSZ)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          ssb_d     = 1'b1;
          done_d    = 1'b1;
          gap_cnt_d = '0;
          if (rw_q == RW_READ) begin
            rd_data_d = shift_rx_q;
          end
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q == GapW'(CS_GAP - 1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rw_q       <= RW_WRITE;
      sclk_q     <= 1'b0;
      ssb_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rw_q       <= rw_d;
      sclk_q     <= sclk_d;
      ssb_q      <= ssb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // The transmit register is all zeros outside a frame, so its MSB doubles as the MOSI flop.
  assign MOSI    = shift_tx_q[PKTSZ-1];
  assign SCLK    = sclk_q;
  assign SSB     = ssb_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV 4 and 2) share a behavioural SPI register
// slave through a select mux; table of frames plus directed multi-cycle sequences.
module tb_spi_master;
  import wes207_spi_pkg::*;

  localparam int unsigned DIV_A = 4;
  localparam int unsigned DIV_B = 2;
  localparam int unsigned GAP_N = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, rw = 1'b0, sel = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wr_data = '0;
  logic       miso = 1'b0;
  logic       busy_a, done_a, sclk_a, ssb_a, mosi_a;
  logic       busy_b, done_b, sclk_b, ssb_b, mosi_b;
  logic [7:0] rd_a, rd_b;
  logic       start_a, start_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  spi_master #(.CLK_DIV(DIV_A), .CS_GAP(GAP_N)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .rw(rw), .addr(addr), .wr_data(wr_data),
    .busy(busy_a), .done(done_a), .rd_data(rd_a), .SCLK(sclk_a), .SSB(ssb_a), .MOSI(mosi_a),
    .MISO(miso)
  );

  spi_master #(.CLK_DIV(DIV_B), .CS_GAP(GAP_N)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .rw(rw), .addr(addr), .wr_data(wr_data),
    .busy(busy_b), .done(done_b), .rd_data(rd_b), .SCLK(sclk_b), .SSB(ssb_b), .MOSI(mosi_b),
    .MISO(miso)
  );

  logic       sclk_m, ssb_m, mosi_m, done_m, busy_m;
  logic [7:0] rd_m;
  assign sclk_m = sel ? sclk_b : sclk_a;
  assign ssb_m  = sel ? ssb_b  : ssb_a;
  assign mosi_m = sel ? mosi_b : mosi_a;
  assign done_m = sel ? done_b : done_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign rd_m   = sel ? rd_b   : rd_a;

  // Behavioural register slave plus event counters, all sampled on the falling clk edge.
  logic [7:0]  regs [128];
  logic        poke_en = 1'b0;
  logic [6:0]  poke_addr = '0;
  logic [7:0]  poke_data = '0;
  logic        ssb_p = 1'b1, sclk_p = 1'b0;
  int          s_cnt = 0, last_cnt = 0;
  logic [15:0] s_rx = '0, last_frame = '0;
  logic [7:0]  hdr = '0;
  int          cyc = 0, done_cnt = 0, ssb_low_cnt = 0, ssb_falls = 0;
  int          last_rise = 0, last_period = 0;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    ssb_p  <= ssb_m;
    sclk_p <= sclk_m;
    if (done_m) done_cnt <= done_cnt + 1;
    if (!ssb_m) ssb_low_cnt <= ssb_low_cnt + 1;
    if (poke_en) regs[poke_addr] <= poke_data;
    if (ssb_p && !ssb_m) begin
      ssb_falls <= ssb_falls + 1;
      s_cnt     <= 0;
      s_rx      <= '0;
    end else if (!ssb_p && ssb_m) begin
      last_frame <= s_rx;
      last_cnt   <= s_cnt;
      if (s_cnt == 16 && s_rx[15] == RW_WRITE) regs[s_rx[14:8]] <= s_rx[7:0];
      miso <= 1'b0;
    end else if (!ssb_m && sclk_m && !sclk_p) begin
      s_rx  <= {s_rx[14:0], mosi_m};
      s_cnt <= s_cnt + 1;
      if (s_cnt == 7) hdr <= {s_rx[6:0], mosi_m};
      last_period <= cyc - last_rise;
      last_rise   <= cyc;
    end else if (!ssb_m && !sclk_m && sclk_p) begin
      if (s_cnt >= 8 && s_cnt < 16) miso <= regs[hdr[6:0]][15-s_cnt];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    #1;
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic wait_idle();
    int m = 0;
    while (busy_m && m < 400) begin
      @(negedge clk);
      m++;
    end
    check("busy_clears", {31'd0, busy_m}, 32'd0);
  endtask

  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd, input string tag);
    int div, exp_lat, n, d0, l0;
    div     = sel ? DIV_B : DIV_A;
    exp_lat = div * (2 * PKTSZ + 2);
    @(negedge clk);
    d0 = done_cnt;
    l0 = ssb_low_cnt;
    start = 1'b1; rw = r; addr = a; wr_data = d;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy_m}, 32'd1);
    n = 0;
    while (!done_m && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_rd_data"}, {24'd0, rd_m}, {24'd0, exp_rd});
    wait_idle();
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_ssb_low"}, ssb_low_cnt - l0, exp_lat);
    check({tag, "_mosi_frame"}, {16'd0, last_frame}, {16'd0, r, a, d});
    check({tag, "_bits"}, last_cnt, 16);
    check({tag, "_sclk_period"}, last_period, 2 * div);
  endtask

  typedef struct {
    logic       sel;
    logic       pre_en;
    logic [6:0] pre_addr;
    logic [7:0] pre_data;
    logic       r;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f0, d0;
    vecs[0] = '{1'b0, 1'b0, 7'h00, 8'h00, RW_WRITE, 7'h05, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 7'h05, 8'h3C, RW_READ,  7'h05, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 7'h00, 8'h00, RW_WRITE, 7'h01, 8'h5A, 8'h3C};
    vecs[3] = '{1'b0, 1'b0, 7'h00, 8'h00, RW_READ,  7'h01, 8'h00, 8'h5A};
    vecs[4] = '{1'b0, 1'b1, 7'h7F, 8'h81, RW_READ,  7'h7F, 8'h00, 8'h81};
    vecs[5] = '{1'b0, 1'b0, 7'h00, 8'h00, RW_WRITE, 7'h00, 8'h00, 8'h81};
    vecs[6] = '{1'b1, 1'b0, 7'h00, 8'h00, RW_WRITE, 7'h7F, 8'hFF, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 7'h00, 8'h00, RW_READ,  7'h7F, 8'h00, 8'hFF};
    vecs[8] = '{1'b1, 1'b0, 7'h00, 8'h00, RW_WRITE, 7'h7F, 8'h00, 8'hFF};
    vecs[9] = '{1'b1, 1'b0, 7'h00, 8'h00, RW_READ,  7'h7F, 8'h00, 8'h00};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_sclk", {31'd0, sclk_a}, 32'd0);
    check("rst_ssb", {31'd0, ssb_a}, 32'd1);
    check("rst_mosi", {31'd0, mosi_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_rd_data", {24'd0, rd_a}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_en) poke(vecs[i].pre_addr, vecs[i].pre_data);
      run_frame(vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end
    check("led0", {31'd0, regs[1][0]}, 32'd0);
    check("led1", {31'd0, regs[1][1]}, 32'd1);

    // start pulsed mid-SHIFT must be ignored.
    @(negedge clk);
    f0 = ssb_falls; d0 = done_cnt;
    start = 1'b1; rw = RW_WRITE; addr = 7'h10; wr_data = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1; addr = 7'h11; wr_data = 8'h44;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("ign_ssb_falls", ssb_falls - f0, 1);
    check("ign_done_pulses", done_cnt - d0, 1);
    check("ign_frame", {16'd0, last_frame}, {16'd0, 16'h1033});

    // start held high re-triggers on the first IDLE cycle after GAP.
    @(negedge clk);
    f0 = ssb_falls;
    start = 1'b1; rw = RW_WRITE; addr = 7'h12; wr_data = 8'h77;
    n = 0;
    while (!done_m && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (ssb_m && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("held_gap", n, GAP_N * DIV_A + 1);
    @(negedge clk);
    wait_idle();
    repeat (5) @(negedge clk);
    check("held_ssb_falls", ssb_falls - f0, 2);

    // Reset at bit 9 of a read.
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; rw = RW_READ; addr = 7'h05; wr_data = 8'h00;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (s_cnt != 9 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_bit9", s_cnt, 9);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ssb", {31'd0, ssb_a}, 32'd1);
    check("rst_mid_sclk", {31'd0, sclk_a}, 32'd0);
    check("rst_mid_rd_data", {24'd0, rd_a}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    run_frame(RW_READ, 7'h05, 8'h00, 8'h3C, "post_rst");

    // CLK_DIV = 2 instance.
    @(negedge clk);
    sel = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 6; i < 10; i++) begin
      run_frame(vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
